// File: rtl/multimode_counter_pkg.sv
// Shared definitions for the multimode counter: the mode encoding.
package multimode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

endpackage : multimode_counter_pkg

// File: rtl/counter_prescaler.sv
// Programmable prescaler: raises o_tick on one enabled cycle out of every i_div+1.
// i_clear (driven by the counter load strobe) restarts the divide sequence.
module counter_prescaler #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_psc;

    // A tick is an enabled cycle in which the count has reached the divisor exactly;
    // a count left above a freshly lowered divisor only wraps, it does not tick.
    assign o_tick = i_en & (r_psc == i_div);

    // Advance the divide count on enabled cycles, wrapping at (or beyond) the divisor.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_psc <= '0;
        end else if (i_clear) begin
            r_psc <= '0;
        end else if (i_en) begin
            if (r_psc >= i_div) begin
                r_psc <= '0;
            end else begin
                r_psc <= r_psc + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule : counter_prescaler

// File: rtl/multimode_counter.sv
// Multimode counter: programmable range 0..limit, up/down/ping-pong/hold modes,
// wrap or saturate at the range ends, synchronous load, prescaled stepping and
// registered one-cycle terminal-count and compare-match pulses.
module multimode_counter
    import multimode_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 sat,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [WIDTH-1:0]     limit,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [WIDTH-1:0]     cmp_val,
    output logic [WIDTH-1:0]     count,
    output logic                 dir,
    output logic                 tc,
    output logic                 match
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_tc;
    logic             r_match;

    mode_t            w_mode;
    logic             w_tick;
    logic             w_step;
    logic             w_write;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_dir_nxt;
    logic             w_tc_nxt;
    logic             w_match_nxt;

    assign w_mode = mode_t'(mode);

    counter_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_en    (en),
        .i_clear (load),
        .i_div   (div),
        .o_tick  (w_tick)
    );

    // Load wins over stepping; HOLD never steps.
    assign w_step  = w_tick & (w_mode != MODE_HOLD) & ~load;
    // Any step or load writes the count, even when the written value is unchanged.
    assign w_write = load | w_step;

    // Next count, direction and terminal-count flag from the current mode rules.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_tc_nxt    = 1'b0;

        if (load) begin
            w_count_nxt = load_val;
            w_dir_nxt   = (w_mode != MODE_DOWN);
        end else begin
            case (w_mode)
                MODE_UP: begin
                    w_dir_nxt = 1'b1;
                    if (w_step) begin
                        if (r_count < limit) begin
                            w_count_nxt = r_count + ONE;
                        end else begin
                            w_count_nxt = sat ? limit : ZERO;
                            w_tc_nxt    = 1'b1;
                        end
                    end
                end
                MODE_DOWN: begin
                    w_dir_nxt = 1'b0;
                    if (w_step) begin
                        if (r_count != ZERO) begin
                            w_count_nxt = r_count - ONE;
                        end else begin
                            w_count_nxt = sat ? ZERO : limit;
                            w_tc_nxt    = 1'b1;
                        end
                    end
                end
                MODE_PINGPONG: begin
                    if (w_step) begin
                        if (limit == ZERO) begin
                            // Degenerate range: sit at 0 and bounce the direction.
                            w_count_nxt = ZERO;
                            w_dir_nxt   = ~r_dir;
                            w_tc_nxt    = 1'b1;
                        end else if (r_dir) begin
                            if (r_count < limit) begin
                                w_count_nxt = r_count + ONE;
                            end else begin
                                w_count_nxt = limit - ONE;
                                w_dir_nxt   = 1'b0;
                                w_tc_nxt    = 1'b1;
                            end
                        end else begin
                            if (r_count != ZERO) begin
                                w_count_nxt = r_count - ONE;
                            end else begin
                                w_count_nxt = ONE;
                                w_dir_nxt   = 1'b1;
                                w_tc_nxt    = 1'b1;
                            end
                        end
                    end
                end
                MODE_HOLD: begin
                    w_count_nxt = r_count;
                    w_dir_nxt   = r_dir;
                end
            endcase
        end
    end

    // Match reflects the value just written, never a compare-value change alone.
    assign w_match_nxt = w_write & (w_count_nxt == cmp_val);

    // Register the count state and its one-cycle status pulses together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_dir   <= 1'b1;
            r_tc    <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_tc    <= w_tc_nxt;
            r_match <= w_match_nxt;
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign tc    = r_tc;
    assign match = r_match;

endmodule : multimode_counter

// File: tb/tb_multimode_counter.sv
// Self-checking bench for multimode_counter: directed vector table, hand-written
// asynchronous-reset sequence, then randomized traffic against a behavioural model.
module tb_multimode_counter;
    import multimode_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sat;
    logic [3:0] div;
    logic [7:0] limit;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cmp_val;
    logic [7:0] count;
    logic       dir;
    logic       tc;
    logic       match;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (plain integers)
    int m_count;
    int m_psc;
    bit m_dir;
    bit m_tc;
    bit m_match;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       sat;
        logic [3:0] div;
        logic [7:0] limit;
        logic       load;
        logic [7:0] load_val;
        logic [7:0] cmp_val;
        logic [7:0] exp_count;
        logic       exp_dir;
        logic       exp_tc;
        logic       exp_match;
    } vec_t;

    vec_t vecs[$];

    multimode_counter #(
        .WIDTH     (8),
        .DIV_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sat      (sat),
        .div      (div),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .cmp_val  (cmp_val),
        .count    (count),
        .dir      (dir),
        .tc       (tc),
        .match    (match)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_psc   = 0;
        m_dir   = 1'b1;
        m_tc    = 1'b0;
        m_match = 1'b0;
    endtask

    // One clock edge of the counter described by its rules, using the current inputs.
    task automatic model_edge();
        int  lim;
        int  nxt;
        bit  tick;
        bit  step;
        lim  = int'(limit);
        tick = en && (m_psc == int'(div));
        step = tick && (mode != MODE_HOLD) && !load;
        if (load)               m_psc = 0;
        else if (en)            m_psc = (m_psc >= int'(div)) ? 0 : m_psc + 1;
        m_tc    = 1'b0;
        m_match = 1'b0;
        if (load) begin
            m_count = int'(load_val);
            m_dir   = (mode != MODE_DOWN);
            m_match = (load_val == cmp_val);
        end else begin
            if (mode == MODE_UP)   m_dir = 1'b1;
            if (mode == MODE_DOWN) m_dir = 1'b0;
            if (step) begin
                nxt = m_count;
                if (mode == MODE_UP) begin
                    nxt = m_count + 1;
                    if (nxt > lim) begin
                        nxt  = sat ? lim : 0;
                        m_tc = 1'b1;
                    end
                end else if (mode == MODE_DOWN) begin
                    nxt = m_count - 1;
                    if (nxt < 0) begin
                        nxt  = sat ? 0 : lim;
                        m_tc = 1'b1;
                    end
                end else if (lim == 0) begin
                    nxt   = 0;
                    m_dir = !m_dir;
                    m_tc  = 1'b1;
                end else begin
                    nxt = m_dir ? m_count + 1 : m_count - 1;
                    if (m_dir && nxt > lim) begin
                        nxt   = lim - 1;
                        m_dir = 1'b0;
                        m_tc  = 1'b1;
                    end else if (!m_dir && nxt < 0) begin
                        nxt   = 1;
                        m_dir = 1'b1;
                        m_tc  = 1'b1;
                    end
                end
                m_count = nxt;
                m_match = (nxt == int'(cmp_val));
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic cycle(input logic e, input logic [1:0] md, input logic s, input logic [3:0] dv,
                         input logic [7:0] lm, input logic ld, input logic [7:0] lv,
                         input logic [7:0] cv);
        en = e; mode = md; sat = s; div = dv; limit = lm;
        load = ld; load_val = lv; cmp_val = cv;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic e, input logic [1:0] md, input logic s, input logic [3:0] dv,
                       input logic [7:0] lm, input logic ld, input logic [7:0] lv,
                       input logic [7:0] cv, input logic [7:0] ec, input logic ed,
                       input logic et, input logic em);
        vec_t v;
        v.en = e; v.mode = md; v.sat = s; v.div = dv; v.limit = lm; v.load = ld;
        v.load_val = lv; v.cmp_val = cv;
        v.exp_count = ec; v.exp_dir = ed; v.exp_tc = et; v.exp_match = em;
        vecs.push_back(v);
    endtask

    task automatic check_model(input string tag);
        check({tag, " count"}, 32'(count), 32'(m_count));
        check({tag, " dir"},   32'(dir),   32'(m_dir));
        check({tag, " tc"},    32'(tc),    32'(m_tc));
        check({tag, " match"}, 32'(match), 32'(m_match));
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; mode = MODE_UP; sat = 1'b0; div = 4'd0;
        limit = 8'd0; load = 1'b0; load_val = 8'd0; cmp_val = 8'd0;
        model_reset();
        #3;
        check("reset count", 32'(count), 32'd0);
        check("reset dir",   32'(dir),   32'd1);
        check("reset tc",    32'(tc),    32'd0);
        check("reset match", 32'(match), 32'd0);
        #9 rst = 1'b0;

        // ---------------- directed vector table ----------------
        // UP, wrap, limit=5, div=0
        row(1, MODE_UP, 0, 0, 5, 1, 0, 200, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++)
            row(1, MODE_UP, 0, 0, 5, 0, 0, 200, 8'(i % 6), 1, (i % 6) == 0, 0);
        // UP, saturate, limit=3, cmp=3
        row(1, MODE_UP, 1, 0, 3, 1, 0, 3, 0, 1, 0, 0);
        row(1, MODE_UP, 1, 0, 3, 0, 0, 3, 1, 1, 0, 0);
        row(1, MODE_UP, 1, 0, 3, 0, 0, 3, 2, 1, 0, 0);
        row(1, MODE_UP, 1, 0, 3, 0, 0, 3, 3, 1, 0, 1);
        row(1, MODE_UP, 1, 0, 3, 0, 0, 3, 3, 1, 1, 1);
        row(1, MODE_UP, 1, 0, 3, 0, 0, 3, 3, 1, 1, 1);
        // PINGPONG, limit=3 (sat set, must be ignored)
        row(1, MODE_PINGPONG, 1, 0, 3, 1, 0, 200, 0, 1, 0, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 1, 1, 0, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 2, 1, 0, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 3, 1, 0, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 2, 0, 1, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 1, 0, 0, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 0, 0, 0, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 1, 1, 1, 0);
        row(1, MODE_PINGPONG, 1, 0, 3, 0, 0, 200, 2, 1, 0, 0);
        // DOWN, wrap, limit=10, load above limit
        row(1, MODE_DOWN, 0, 0, 10, 1, 200, 198, 200, 0, 0, 0);
        row(1, MODE_DOWN, 0, 0, 10, 0, 0,   198, 199, 0, 0, 0);
        row(1, MODE_DOWN, 0, 0, 10, 0, 0,   198, 198, 0, 0, 1);
        row(1, MODE_DOWN, 0, 0, 10, 0, 0,   198, 197, 0, 0, 0);
        row(1, MODE_DOWN, 0, 0, 10, 1, 0,   198, 0,   0, 0, 0);
        row(1, MODE_DOWN, 0, 0, 10, 0, 0,   198, 10,  0, 1, 0);
        // DOWN, saturate at 0; idle cycle in saturation has no tc
        row(1, MODE_DOWN, 1, 0, 10, 1, 0, 198, 0, 0, 0, 0);
        row(1, MODE_DOWN, 1, 0, 10, 0, 0, 198, 0, 0, 1, 0);
        row(0, MODE_DOWN, 1, 0, 10, 0, 0, 198, 0, 0, 0, 0);
        // PINGPONG with limit=0, cmp=0
        row(1, MODE_PINGPONG, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        row(1, MODE_PINGPONG, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        row(1, MODE_PINGPONG, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // HOLD: load works, then frozen; cmp change alone never matches
        row(1, MODE_HOLD, 0, 0, 20, 1, 9, 9, 9, 1, 0, 1);
        row(1, MODE_HOLD, 0, 0, 20, 0, 0, 9, 9, 1, 0, 0);
        row(1, MODE_HOLD, 0, 0, 20, 0, 0, 5, 9, 1, 0, 0);
        row(0, MODE_DOWN, 0, 0, 20, 0, 0, 9, 9, 0, 0, 0);
        // Prescaler div=2: en 1,1,0,1; then load at psc=1 restarts the divide
        row(1, MODE_UP, 0, 2, 20, 1, 0, 200, 0, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 0, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 0, 1, 0, 0);
        row(0, MODE_UP, 0, 2, 20, 0, 0, 200, 0, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 1, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 1, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 1, 1, 200, 1, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 1, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 1, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 2, 1, 0, 0);
        // Divisor lowered below psc: wrap cycle is not a tick
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 2, 1, 0, 0);
        row(1, MODE_UP, 0, 2, 20, 0, 0, 200, 2, 1, 0, 0);
        row(1, MODE_UP, 0, 0, 20, 0, 0, 200, 2, 1, 0, 0);
        row(1, MODE_UP, 0, 0, 20, 0, 0, 200, 3, 1, 0, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].mode, vecs[i].sat, vecs[i].div, vecs[i].limit,
                  vecs[i].load, vecs[i].load_val, vecs[i].cmp_val);
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d dir", i),   32'(dir),   32'(vecs[i].exp_dir));
            check($sformatf("vec%0d tc", i),    32'(tc),    32'(vecs[i].exp_tc));
            check($sformatf("vec%0d match", i), 32'(match), 32'(vecs[i].exp_match));
        end

        // ---------------- asynchronous reset mid-count ----------------
        cycle(1, MODE_UP, 0, 0, 20, 1, 0, 7);
        for (int i = 0; i < 7; i++) cycle(1, MODE_UP, 0, 0, 20, 0, 0, 7);
        check("pre-rst count", 32'(count), 32'd7);
        check("pre-rst match", 32'(match), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst count", 32'(count), 32'd0);
        check("async rst dir",   32'(dir),   32'd1);
        check("async rst tc",    32'(tc),    32'd0);
        check("async rst match", 32'(match), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        cycle(1, MODE_UP, 0, 0, 20, 0, 0, 7);
        check("post-rst count1", 32'(count), 32'd1);
        cycle(1, MODE_UP, 0, 0, 20, 0, 0, 7);
        check("post-rst count2", 32'(count), 32'd2);
        check_model("post-rst model");

        // ---------------- randomized traffic vs model ----------------
        begin
            logic [1:0] r_md = MODE_UP;
            logic       r_s  = 1'b0;
            logic [3:0] r_dv = 4'd0;
            logic [7:0] r_lm = 8'd10;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 19) == 0) r_md = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0)  r_s  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 14) == 0) r_dv = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 24) == 0)
                    r_lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
                cycle(($urandom_range(0, 4) != 0), r_md, r_s, r_dv, r_lm,
                      ($urandom_range(0, 24) == 0),
                      ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 14)),
                      8'($urandom_range(0, 12)));
                check_model($sformatf("rand%0d", n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multimode_counter
